// File: rtl/toeplitz_stream.sv
// Streaming Toeplitz extractor: compresses each N-bit raw block to L bits using
// a run-time loaded (N+L-1)-bit seed, with a one-deep output register.
module toeplitz_stream #(
  parameter int N     = 256,
  parameter int L     = 128,
  parameter int WIDTH = 2,
  parameter int SW    = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_seed_we,
  input  logic [SW-1:0]    i_seed_data,
  output logic             o_seed_ok,
  output logic             o_seed_err,
  output logic [L-1:0]     o_q,
  output logic             o_out_valid,
  input  logic             i_out_ready
);

  localparam int S   = N + L - 1;
  localparam int SWN = (S + SW - 1) / SW;
  localparam int IW  = (SWN > 1) ? $clog2(SWN) : 1;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int WIN = L + WIDTH - 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - WIDTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(SWN - 1);

  logic [S-1:0]    r_seed;
  logic [IW-1:0]   r_seed_idx;
  logic [CW-1:0]   r_cnt;
  logic [L-1:0]    r_y;
  logic [L-1:0]    r_q;
  logic            r_out_valid;
  logic            r_seed_ok;
  logic            r_seed_err;

  logic            w_cnt_zero;
  logic            w_last;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_seed_wr;
  logic [CW-1:0]   w_base;
  logic [WIN-1:0]  w_win;
  logic [L-1:0]    w_contrib;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_last     = (r_cnt == CNT_LAST);
  // Input is blocked during any seed reload and while a finished block would
  // overwrite an unconsumed q.
  assign w_in_ready = r_seed_ok & (r_seed_idx == '0) & ~i_seed_we
                      & ~(w_last & r_out_valid);
  assign w_accept   = i_in_valid & w_in_ready;
  assign w_seed_wr  = i_seed_we & w_cnt_zero;

  // Raw bit j = cnt+k meets seed index i+N-1-j. Shifting the seed down by
  // N-WIDTH-cnt leaves a fixed window where that index is i+WIDTH-1-k.
  assign w_base = CNT_LAST - r_cnt;
  assign w_win  = WIN'(r_seed >> w_base);

  // XOR contribution of the current WIDTH raw bits to every output row.
  always_comb begin
    w_contrib = '0;
    for (int i = 0; i < L; i++) begin
      for (int k = 0; k < WIDTH; k++) begin
        w_contrib[i] = w_contrib[i] ^ (w_win[i + WIDTH - 1 - k] & i_data[k]);
      end
    end
  end

  // Seed storage: an accepted write fills the word selected by seed_idx;
  // bits past the end of the seed are dropped.
  always_ff @(posedge i_clk) begin
    if (w_seed_wr) begin
      for (int p = 0; p < S; p++) begin
        if (r_seed_idx == IW'(p / SW)) begin
          r_seed[p] <= i_seed_data[p % SW];
        end
      end
    end
  end

  // Seed load sequencing: word index, sticky completion flag, reject pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_seed_idx <= '0;
      r_seed_ok  <= 1'b0;
      r_seed_err <= 1'b0;
    end else begin
      r_seed_err <= i_seed_we & ~w_cnt_zero;
      if (w_seed_wr) begin
        if (r_seed_idx == IDX_LAST) begin
          r_seed_idx <= '0;
          r_seed_ok  <= 1'b1;
        end else begin
          r_seed_idx <= r_seed_idx + IW'(1);
        end
      end
    end
  end

  // Block accumulation: fold each transfer into y, publish y on the final one.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_y   <= '0;
      r_q   <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_q   <= r_y ^ w_contrib;
        r_y   <= '0;
        r_cnt <= '0;
      end else begin
        r_y   <= r_y ^ w_contrib;
        r_cnt <= r_cnt + CW'(WIDTH);
      end
    end
  end

  // Output valid flag: set on block completion, cleared on consumer handshake.
  // The stall on the final transfer keeps the two from coinciding.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
    end else if (w_accept & w_last) begin
      r_out_valid <= 1'b1;
    end else if (r_out_valid & i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_seed_ok   = r_seed_ok;
  assign o_seed_err  = r_seed_err;
  assign o_q         = r_q;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_toeplitz_stream.sv
// Bench for toeplitz_stream: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a matrix-level model.
module tb_toeplitz_stream;

  localparam int N     = 8;
  localparam int L     = 4;
  localparam int WIDTH = 2;
  localparam int SW    = 4;
  localparam int S     = N + L - 1;
  localparam int SWN   = (S + SW - 1) / SW;

  logic             i_clk;
  logic             i_reset;
  logic [WIDTH-1:0] i_data;
  logic             i_in_valid;
  logic             o_in_ready;
  logic             i_seed_we;
  logic [SW-1:0]    i_seed_data;
  logic             o_seed_ok;
  logic             o_seed_err;
  logic [L-1:0]     o_q;
  logic             o_out_valid;
  logic             i_out_ready;

  toeplitz_stream #(.N(N), .L(L), .WIDTH(WIDTH), .SW(SW)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_data      (i_data),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_seed_we   (i_seed_we),
    .i_seed_data (i_seed_data),
    .o_seed_ok   (o_seed_ok),
    .o_seed_err  (o_seed_err),
    .o_q         (o_q),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Behavioural model: seed as a bit array, raw block as a bit array, q from
  // the matrix definition when a block fills up.
  bit         m_seed [S];
  bit         m_x    [N];
  int         m_sidx;
  bit         m_ok;
  int         m_cnt;
  logic [L-1:0] m_q;
  bit         m_ov;
  bit         m_err;
  bit         m_live = 1'b0;

  bit           mv_rdy, mv_old_ov, mv_done;
  logic [L-1:0] mv_acc;

  function automatic bit exp_ready();
    return m_ok && (m_sidx == 0) && !i_seed_we && !((m_cnt == N - WIDTH) && m_ov);
  endfunction

  always @(posedge i_clk) begin
    if (i_reset) begin
      m_sidx = 0; m_ok = 0; m_cnt = 0; m_q = '0; m_ov = 0; m_err = 0;
      m_live = 1'b1;
    end else begin
      mv_rdy    = exp_ready();
      mv_old_ov = m_ov;
      mv_done   = 1'b0;
      m_err     = i_seed_we && (m_cnt != 0);
      if (i_seed_we && m_cnt == 0) begin
        for (int b = 0; b < SW; b++)
          if (m_sidx * SW + b < S) m_seed[m_sidx * SW + b] = i_seed_data[b];
        if (m_sidx == SWN - 1) begin
          m_sidx = 0;
          m_ok   = 1'b1;
        end else begin
          m_sidx = m_sidx + 1;
        end
      end
      if (i_in_valid && mv_rdy) begin
        for (int k = 0; k < WIDTH; k++) m_x[m_cnt + k] = i_data[k];
        m_cnt = m_cnt + WIDTH;
        if (m_cnt == N) begin
          mv_acc = '0;
          for (int i = 0; i < L; i++)
            for (int j = 0; j < N; j++)
              mv_acc[i] = mv_acc[i] ^ (m_seed[i + N - 1 - j] & m_x[j]);
          m_q     = mv_acc;
          m_cnt   = 0;
          mv_done = 1'b1;
        end
      end
      if (mv_done) m_ov = 1'b1;
      else if (mv_old_ov && i_out_ready) m_ov = 1'b0;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge i_clk) begin
    #2;
    if (m_live) begin
      cmp("in_ready",  32'(o_in_ready),  32'(exp_ready()));
      cmp("out_valid", 32'(o_out_valid), 32'(m_ov));
      cmp("q",         32'(o_q),         32'(m_q));
      cmp("seed_ok",   32'(o_seed_ok),   32'(m_ok));
      cmp("seed_err",  32'(o_seed_err),  32'(m_err));
    end
  end

  // Tasks start and end on a falling edge.
  task automatic send(input logic [WIDTH-1:0] d);
    bit done;
    bit rdy;
    done = 1'b0;
    i_in_valid = 1'b1;
    i_data     = d;
    for (int t = 0; t < 40 && !done; t++) begin
      #4 rdy = o_in_ready;
      @(negedge i_clk);
      if (rdy) done = 1'b1;
    end
    i_in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_errs++;
      $display("FAIL send_timeout data %0h never accepted at %0t", d, $time);
    end
  endtask

  task automatic wr_seed(input logic [SW-1:0] w);
    i_seed_we   = 1'b1;
    i_seed_data = w;
    @(negedge i_clk);
    i_seed_we   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_data = '0; i_in_valid = 1'b0; i_seed_we = 1'b0;
    i_seed_data = '0; i_out_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    #3;
    cmp("rst_q",        32'(o_q),         32'h0);
    cmp("rst_out_valid",32'(o_out_valid), 32'h0);
    cmp("rst_seed_ok",  32'(o_seed_ok),   32'h0);
    cmp("rst_in_ready", 32'(o_in_ready),  32'h0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // No seed yet: input must be refused.
    i_in_valid = 1'b1; i_data = 2'b11;
    repeat (3) @(negedge i_clk);
    #3;
    cmp("noseed_in_ready",  32'(o_in_ready),  32'h0);
    cmp("noseed_out_valid", 32'(o_out_valid), 32'h0);
    @(negedge i_clk);
    i_in_valid = 1'b0;

    // Identity seed: s[7]=1 only, so q[i] = x[i].
    wr_seed(4'h0); wr_seed(4'h8); wr_seed(4'h0);
    #3 cmp("ident_seed_ok", 32'(o_seed_ok), 32'h1);
    @(negedge i_clk);
    send(2'b10); send(2'b01); send(2'b11); send(2'b00);
    #3;
    cmp("ident_out_valid", 32'(o_out_valid), 32'h1);
    cmp("ident_q",         32'(o_q),         32'h6);
    @(negedge i_clk);

    // All-ones seed: q bits are the parity of the block.
    wr_seed(4'hF); wr_seed(4'hF); wr_seed(4'hF);
    send(2'b01); send(2'b00); send(2'b00); send(2'b00);
    #3 cmp("ones_q_odd", 32'(o_q), 32'hF);
    @(negedge i_clk);
    repeat (4) send(2'b11);
    #3 cmp("ones_q_even", 32'(o_q), 32'h0);
    @(negedge i_clk);

    // Backpressure: second block stalls at its final transfer.
    i_out_ready = 1'b0;
    send(2'b01); send(2'b00); send(2'b00); send(2'b00);
    #3 cmp("bp_first_q", 32'(o_q), 32'hF);
    @(negedge i_clk);
    repeat (3) send(2'b11);
    i_in_valid = 1'b1; i_data = 2'b11;
    repeat (2) @(negedge i_clk);
    #3;
    cmp("bp_stall_ready", 32'(o_in_ready), 32'h0);
    cmp("bp_hold_q",      32'(o_q),        32'hF);
    @(negedge i_clk);
    i_out_ready = 1'b1;
    @(negedge i_clk);
    #3;
    cmp("bp_cleared_ov", 32'(o_out_valid), 32'h0);
    cmp("bp_ready_back", 32'(o_in_ready),  32'h1);
    @(negedge i_clk);
    i_in_valid = 1'b0;
    #3;
    cmp("bp_second_q",  32'(o_q),         32'h0);
    cmp("bp_second_ov", 32'(o_out_valid), 32'h1);
    @(negedge i_clk);

    // Seed write mid-block is rejected; block finishes with the old seed.
    send(2'b00);
    wr_seed(4'h0);
    #3 cmp("err_pulse", 32'(o_seed_err), 32'h1);
    @(negedge i_clk);
    #3 cmp("err_pulse_end", 32'(o_seed_err), 32'h0);
    @(negedge i_clk);
    send(2'b00); send(2'b00); send(2'b10);
    #3 cmp("err_old_seed_q", 32'(o_q), 32'hF);
    @(negedge i_clk);

    // Seed write with in_valid at cnt==0: write wins, input blocked.
    i_in_valid = 1'b1; i_data = 2'b01;
    i_seed_we = 1'b1; i_seed_data = 4'h0;
    #3 cmp("we_blocks_ready", 32'(o_in_ready), 32'h0);
    @(negedge i_clk);
    i_seed_we = 1'b0;
    #3 cmp("reload_blocks_ready", 32'(o_in_ready), 32'h0);
    @(negedge i_clk);
    i_in_valid = 1'b0;
    wr_seed(4'hF); wr_seed(4'hF);
    send(2'b00); send(2'b00); send(2'b00); send(2'b10);
    #3 cmp("stored_word_q", 32'(o_q), 32'h0);
    @(negedge i_clk);

    // Reset mid-block at cnt=4.
    send(2'b01); send(2'b01);
    i_reset = 1'b1;
    @(negedge i_clk);
    #3;
    cmp("midrst_seed_ok",  32'(o_seed_ok),   32'h0);
    cmp("midrst_ov",       32'(o_out_valid), 32'h0);
    cmp("midrst_q",        32'(o_q),         32'h0);
    cmp("midrst_in_ready", 32'(o_in_ready),  32'h0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // Randomized traffic against the model.
    wr_seed(SW'($urandom)); wr_seed(SW'($urandom)); wr_seed(SW'($urandom));
    for (int c = 0; c < 3000; c++) begin
      i_in_valid  = ($urandom_range(0, 9) < 7);
      i_data      = WIDTH'($urandom);
      i_out_ready = ($urandom_range(0, 9) < 6);
      i_seed_we   = ($urandom_range(0, 99) < 4);
      i_seed_data = SW'($urandom);
      i_reset     = ($urandom_range(0, 999) < 3);
      @(negedge i_clk);
    end
    i_reset = 1'b0; i_in_valid = 1'b0; i_seed_we = 1'b0; i_out_ready = 1'b1;
    repeat (4) @(negedge i_clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
